axis_pkt_arbiter: RTL and testbench

- Packet-level round-robin arbiter that merges NUM_PORTS AXI-Stream sources onto one AXI-Stream sink.
- Sits in front of axis_fifo so several producers can share one FIFO write port.
- Once a port is granted, the grant is held until that port's tlast beat is accepted, so packets are never interleaved.
- Output has one registered stage, giving full-throughput streaming once a packet is flowing.

---
 rtl/axis_pkt_arbiter_pkg.sv | 18 +
 rtl/axis_pkt_arbiter_if.sv | 43 ++++
 rtl/axis_pkt_arbiter_rr_pick.sv | 32 +++
 rtl/axis_pkt_arbiter.sv | 121 ++++++++++++
 tb/tb_axis_pkt_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkt_arbiter_pkg.sv
// rtl/axis_pkt_arbiter_pkg.sv - shared state encoding and width helper for the packet arbiter
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_pkt_arbiter_if.sv
// rtl/axis_pkt_arbiter_if.sv - upstream/downstream stream bundle; s_tdest exists with AXIS_PKT_ARBITER_TDEST_EN
interface axis_pkt_arbiter_if
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int GRANT_W = clog2(NUM_PORTS);

  logic [NUM_PORTS*DATA_WIDTH-1:0] m_tdata;
  logic [NUM_PORTS-1:0]            m_tvalid;
  logic [NUM_PORTS-1:0]            m_tready;
  logic [NUM_PORTS-1:0]            m_tlast;
  logic [DATA_WIDTH-1:0]           s_tdata;
  logic                            s_tvalid;
  logic                            s_tready;
  logic                            s_tlast;
  logic                            grant_valid;
  logic [GRANT_W-1:0]              grant_idx;

`ifdef AXIS_PKT_ARBITER_TDEST_EN
  logic [GRANT_W-1:0]              s_tdest;

  modport master (
    output m_tdata, m_tvalid, m_tlast, s_tready,
    input  m_tready, s_tdata, s_tvalid, s_tlast, grant_valid, grant_idx, s_tdest
  );
  modport slave (
    input  m_tdata, m_tvalid, m_tlast, s_tready,
    output m_tready, s_tdata, s_tvalid, s_tlast, grant_valid, grant_idx, s_tdest
  );
`else
  modport master (
    output m_tdata, m_tvalid, m_tlast, s_tready,
    input  m_tready, s_tdata, s_tvalid, s_tlast, grant_valid, grant_idx
  );
  modport slave (
    input  m_tdata, m_tvalid, m_tlast, s_tready,
    output m_tready, s_tdata, s_tvalid, s_tlast, grant_valid, grant_idx
  );
`endif

endinterface

// File: rtl/axis_pkt_arbiter_rr_pick.sv
// rtl/axis_pkt_arbiter_rr_pick.sv - combinational round-robin picker (rotate then priority-encode)
module axis_rr_pick
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  localparam int GRANT_W  = clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [GRANT_W-1:0]   prev_i,
  output logic [GRANT_W-1:0]   idx_o,
  output logic                 any_req_o
);

  logic [NUM_PORTS-1:0] rot;
  logic [GRANT_W-1:0]   pos;

  // rot[k] is the request of the port k+1 places after the previous owner
  always_comb begin
    rot       = '0;
    pos       = '0;
    idx_o     = prev_i;
    any_req_o = |req_i;
    for (int k = 0; k < NUM_PORTS; k++) begin
      pos    = GRANT_W'((int'(prev_i) + 1 + k) % NUM_PORTS);
      rot[k] = req_i[pos];
    end
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (rot[k]) idx_o = GRANT_W'((int'(prev_i) + 1 + k) % NUM_PORTS);
    end
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// rtl/axis_pkt_arbiter.sv - packet-level round-robin merge of NUM_PORTS streams into one registered stream
// Optional source-index sideband s_tdest enabled by AXIS_PKT_ARBITER_TDEST_EN.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8
) (
  input logic               aclk,
  input logic               areset_n,
  axis_pkt_arbiter_if.slave bus
);
  localparam int GRANT_W = clog2(NUM_PORTS);

  arb_state_e            state_q, state_d;
  logic [GRANT_W-1:0]    grant_idx_q, grant_idx_d;
  logic [GRANT_W-1:0]    pick_idx;
  logic                  any_req;
  logic                  s_tvalid_q, s_tvalid_d;
  logic                  s_tlast_q, s_tlast_d;
  logic [DATA_WIDTH-1:0] s_tdata_q, s_tdata_d;
  logic [NUM_PORTS-1:0]  m_tready_c;
  logic                  sel_valid, sel_last, slot_free, take;
  logic [DATA_WIDTH-1:0] sel_data;
`ifdef AXIS_PKT_ARBITER_TDEST_EN
  logic [GRANT_W-1:0]    s_tdest_q, s_tdest_d;
`endif

  axis_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req_i     (bus.m_tvalid),
    .prev_i    (grant_idx_q),
    .idx_o     (pick_idx),
    .any_req_o (any_req)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_idx_q == GRANT_W'(i)) begin
        sel_valid = bus.m_tvalid[i];
        sel_last  = bus.m_tlast[i];
        sel_data  = bus.m_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    s_tvalid_d  = s_tvalid_q;
    s_tdata_d   = s_tdata_q;
    s_tlast_d   = s_tlast_q;
    m_tready_c  = '0;
    take        = 1'b0;
    slot_free   = bus.s_tready | ~s_tvalid_q;
`ifdef AXIS_PKT_ARBITER_TDEST_EN
    s_tdest_d   = s_tdest_q;
`endif
    // Drain first; a beat taken in the same cycle overrides it below.
    if (s_tvalid_q && bus.s_tready) s_tvalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_idx_d = pick_idx;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (grant_idx_q == GRANT_W'(i)) m_tready_c[i] = slot_free;
        end
        take = sel_valid & slot_free;
        if (take) begin
          s_tvalid_d = 1'b1;
          s_tdata_d  = sel_data;
          s_tlast_d  = sel_last;
`ifdef AXIS_PKT_ARBITER_TDEST_EN
          s_tdest_d  = grant_idx_q;
`endif
          if (sel_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= IDLE;
      grant_idx_q <= GRANT_W'(NUM_PORTS - 1);
      s_tvalid_q  <= 1'b0;
      s_tdata_q   <= '0;
      s_tlast_q   <= 1'b0;
`ifdef AXIS_PKT_ARBITER_TDEST_EN
      s_tdest_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      s_tvalid_q  <= s_tvalid_d;
      s_tdata_q   <= s_tdata_d;
      s_tlast_q   <= s_tlast_d;
`ifdef AXIS_PKT_ARBITER_TDEST_EN
      s_tdest_q   <= s_tdest_d;
`endif
    end
  end

  assign bus.m_tready    = m_tready_c;
  assign bus.s_tdata     = s_tdata_q;
  assign bus.s_tvalid    = s_tvalid_q;
  assign bus.s_tlast     = s_tlast_q;
  assign bus.grant_valid = (state_q == BUSY);
  assign bus.grant_idx   = grant_idx_q;
`ifdef AXIS_PKT_ARBITER_TDEST_EN
  assign bus.s_tdest     = s_tdest_q;
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb/tb_axis_pkt_arbiter.sv - directed self-checking bench for axis_pkt_arbiter
module tb_axis_pkt_arbiter;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   cyc_n;

  logic [8:0] srcq [4][$];
  logic [3:0] hold;
  logic [3:0] vprev;
  int         rise_cyc [4];

  logic [7:0] out_d [$];
  logic       out_l [$];
  int         out_c [$];

  axis_pkt_arbiter_if #(.NUM_PORTS(4), .DATA_WIDTH(8)) intf ();

  axis_pkt_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(8)) dut (
    .aclk     (clk),
    .areset_n (rst_n),
    .bus      (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-port sources: head of queue is presented unless held
  initial begin
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    intf.m_tvalid = '0;
    intf.m_tdata  = '0;
    intf.m_tlast  = '0;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 4; i++)
        if (intf.m_tvalid[i] && intf.m_tready[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      #1;
      v = '0; l = '0; d = '0;
      for (int i = 0; i < 4; i++) begin
        if (srcq[i].size() > 0 && !hold[i]) begin
          v[i]        = 1'b1;
          d[i*8 +: 8] = srcq[i][0][7:0];
          l[i]        = srcq[i][0][8];
        end
      end
      intf.m_tvalid = v;
      intf.m_tdata  = d;
      intf.m_tlast  = l;
    end
  end

  initial begin
    cyc_n = 0;
    vprev = '0;
    for (int i = 0; i < 4; i++) rise_cyc[i] = 0;
    forever begin
      @(posedge clk);
      cyc_n = cyc_n + 1;
      for (int i = 0; i < 4; i++) begin
        if (intf.m_tvalid[i] === 1'b1 && !vprev[i]) rise_cyc[i] = cyc_n;
        vprev[i] = (intf.m_tvalid[i] === 1'b1);
      end
      if (rst_n && intf.s_tvalid === 1'b1 && intf.s_tready === 1'b1) begin
        out_d.push_back(intf.s_tdata);
        out_l.push_back(intf.s_tlast);
        out_c.push_back(cyc_n);
      end
    end
  end

  task automatic push(input int p, input logic [7:0] d, input logic last);
    srcq[p].push_back({last, d});
  endtask

  task automatic clear_out();
    out_d.delete(); out_l.delete(); out_c.delete();
  endtask

  task automatic flush_src();
    for (int i = 0; i < 4; i++) srcq[i].delete();
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (out_d.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (out_d.size() < n) begin
      tests++; fails++;
      $display("FAIL %s timeout: got %0d beats, required %0d", name, out_d.size(), n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flush_src();
    hold = '0;
    intf.s_tready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_out();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hold = '0;
    intf.s_tready = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (intf.s_tvalid !== 1'b0) begin fails++; $display("FAIL reset_s_tvalid: got %b, required 0", intf.s_tvalid); end
    tests++; if (intf.s_tdata !== 8'h00) begin fails++; $display("FAIL reset_s_tdata: got %h, required 00", intf.s_tdata); end
    tests++; if (intf.s_tlast !== 1'b0) begin fails++; $display("FAIL reset_s_tlast: got %b, required 0", intf.s_tlast); end
    tests++; if (intf.m_tready !== 4'b0000) begin fails++; $display("FAIL reset_m_tready: got %b, required 0000", intf.m_tready); end
    tests++; if (intf.grant_valid !== 1'b0) begin fails++; $display("FAIL reset_grant_valid: got %b, required 0", intf.grant_valid); end
    tests++; if (intf.grant_idx !== 2'd3) begin fails++; $display("FAIL reset_grant_idx: got %0d, required 3", intf.grant_idx); end
`ifdef AXIS_PKT_ARBITER_TDEST_EN
    tests++; if (intf.s_tdest !== 2'd0) begin fails++; $display("FAIL reset_s_tdest: got %0d, required 0", intf.s_tdest); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_port();
    logic [7:0] exp_d [3];
    logic       exp_l [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    exp_l[0] = 1'b0;  exp_l[1] = 1'b0;  exp_l[2] = 1'b1;
    clear_out();
    @(negedge clk);
    for (int i = 0; i < 3; i++) push(0, exp_d[i], exp_l[i]);
    wait_beats(3, 40, "single");
    for (int i = 0; i < 3; i++) begin
      tests++; if (out_d[i] !== exp_d[i]) begin fails++; $display("FAIL single_data[%0d]: got %h, required %h", i, out_d[i], exp_d[i]); end
      tests++; if (out_l[i] !== exp_l[i]) begin fails++; $display("FAIL single_last[%0d]: got %b, required %b", i, out_l[i], exp_l[i]); end
    end
    tests++; if (out_c[0] !== rise_cyc[0] + 2) begin fails++; $display("FAIL single_latency: got %0d cycles, required 2", out_c[0] - rise_cyc[0]); end
    tests++; if (out_c[2] !== out_c[0] + 2) begin fails++; $display("FAIL single_back_to_back: got span %0d, required 2", out_c[2] - out_c[0]); end
    repeat (2) @(negedge clk);
    tests++; if (intf.grant_idx !== 2'd0) begin fails++; $display("FAIL single_grant_idx: got %0d, required 0", intf.grant_idx); end
    tests++; if (intf.grant_valid !== 1'b0) begin fails++; $display("FAIL single_grant_idle: got %b, required 0", intf.grant_valid); end
  endtask

  task automatic test_contention();
    logic [7:0] e;
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      clear_out();
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
        push(p, 8'(p * 16), 1'b0);
        push(p, 8'(p * 16 + 1), 1'b1);
      end
      wait_beats(8, 100, "contention");
      for (int k = 0; k < 8; k++) begin
        e = 8'((k / 2) * 16 + (k % 2));
        tests++; if (out_d[k] !== e) begin fails++; $display("FAIL contention_order rep%0d beat%0d: got %h, required %h", rep, k, out_d[k], e); end
      end
      for (int k = 1; k < 8; k++) begin
        tests++;
        if (out_c[k] - out_c[k-1] !== ((k % 2) ? 1 : 2)) begin
          fails++; $display("FAIL contention_gap rep%0d beat%0d: got %0d, required %0d", rep, k, out_c[k] - out_c[k-1], (k % 2) ? 1 : 2);
        end
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h3A; exp_d[1] = 8'h1A; exp_d[2] = 8'h3B; exp_d[3] = 8'h1B;
    clear_out();
    @(negedge clk);
    push(1, 8'h1F, 1'b1);
    wait_beats(1, 40, "fair_setup");
    repeat (2) @(negedge clk);
    tests++; if (intf.grant_idx !== 2'd1) begin fails++; $display("FAIL fair_setup_owner: got %0d, required 1", intf.grant_idx); end
    clear_out();
    push(1, 8'h1A, 1'b1); push(1, 8'h1B, 1'b1);
    push(3, 8'h3A, 1'b1); push(3, 8'h3B, 1'b1);
    wait_beats(4, 60, "fairness");
    for (int k = 0; k < 4; k++) begin
      tests++; if (out_d[k] !== exp_d[k]) begin fails++; $display("FAIL fairness_order[%0d]: got %h, required %h", k, out_d[k], exp_d[k]); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int k;
    clear_out();
    intf.s_tready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(2, 8'(8'h21 + i), (i == 3));
    k = 0;
    while (intf.s_tvalid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    tests++; if (intf.s_tdata !== 8'h21) begin fails++; $display("FAIL bp_first: got %h, required 21", intf.s_tdata); end
    @(posedge clk); #1 intf.s_tready = 1'b0;
    @(negedge clk);
    tests++; if (intf.s_tdata !== 8'h22) begin fails++; $display("FAIL bp_stall1_data: got %h, required 22", intf.s_tdata); end
    tests++; if (intf.m_tready[2] !== 1'b0) begin fails++; $display("FAIL bp_stall1_ready: got %b, required 0", intf.m_tready[2]); end
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if (intf.s_tdata !== 8'h22) begin fails++; $display("FAIL bp_stall2_data: got %h, required 22", intf.s_tdata); end
    tests++; if (intf.m_tready[2] !== 1'b0) begin fails++; $display("FAIL bp_stall2_ready: got %b, required 0", intf.m_tready[2]); end
    tests++; if (intf.s_tvalid !== 1'b1) begin fails++; $display("FAIL bp_stall2_valid: got %b, required 1", intf.s_tvalid); end
    @(posedge clk); #1 intf.s_tready = 1'b1;
    @(negedge clk);
    tests++; if (intf.m_tready[2] !== 1'b1) begin fails++; $display("FAIL bp_resume_ready: got %b, required 1", intf.m_tready[2]); end
    wait_beats(4, 40, "backpressure");
    for (int i = 0; i < 4; i++) begin
      tests++; if (out_d[i] !== 8'(8'h21 + i)) begin fails++; $display("FAIL bp_order[%0d]: got %h, required %h", i, out_d[i], 8'(8'h21 + i)); end
      tests++; if (out_l[i] !== (i == 3)) begin fails++; $display("FAIL bp_last[%0d]: got %b, required %b", i, out_l[i], (i == 3)); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_source_gap();
    int k;
    logic [7:0] exp_d [6];
    exp_d[0] = 8'h51; exp_d[1] = 8'h52; exp_d[2] = 8'h53;
    exp_d[3] = 8'h54; exp_d[4] = 8'h61; exp_d[5] = 8'h62;
    clear_out();
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(1, exp_d[i], (i == 3));
    k = 0;
    while (!(intf.grant_valid === 1'b1 && intf.grant_idx === 2'd1) && k < 20) begin @(negedge clk); k++; end
    tests++; if (intf.grant_idx !== 2'd1) begin fails++; $display("FAIL gap_first_grant: got %0d, required 1", intf.grant_idx); end
    hold[1] = 1'b1;
    push(0, 8'h61, 1'b0); push(0, 8'h62, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (intf.grant_valid !== 1'b1 || intf.grant_idx !== 2'd1) begin
        fails++; $display("FAIL gap_hold[%0d]: got valid %b idx %0d, required valid 1 idx 1", c, intf.grant_valid, intf.grant_idx);
      end
    end
    hold[1] = 1'b0;
    wait_beats(6, 60, "source_gap");
    for (int i = 0; i < 6; i++) begin
      tests++; if (out_d[i] !== exp_d[i]) begin fails++; $display("FAIL gap_order[%0d]: got %h, required %h", i, out_d[i], exp_d[i]); end
    end
    repeat (2) @(negedge clk);
    tests++; if (intf.grant_idx !== 2'd0) begin fails++; $display("FAIL gap_final_owner: got %0d, required 0", intf.grant_idx); end
  endtask

  task automatic test_reset_mid_packet();
    clear_out();
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(2, 8'(8'h71 + i), (i == 3));
    wait_beats(2, 40, "rst_mid_pre");
    rst_n = 1'b0;
    flush_src();
    #1;
    tests++; if (intf.s_tvalid !== 1'b0) begin fails++; $display("FAIL rstmid_s_tvalid: got %b, required 0", intf.s_tvalid); end
    tests++; if (intf.m_tready !== 4'b0000) begin fails++; $display("FAIL rstmid_m_tready: got %b, required 0000", intf.m_tready); end
    tests++; if (intf.grant_idx !== 2'd3) begin fails++; $display("FAIL rstmid_grant_idx: got %0d, required 3", intf.grant_idx); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_out();
    push(3, 8'h83, 1'b1);
    push(0, 8'h80, 1'b1);
    wait_beats(2, 40, "rst_mid_post");
    tests++; if (out_d[0] !== 8'h80) begin fails++; $display("FAIL rstmid_first_winner: got %h, required 80", out_d[0]); end
    tests++; if (out_d[1] !== 8'h83) begin fails++; $display("FAIL rstmid_second: got %h, required 83", out_d[1]); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    hold  = '0;
    rst_n = 1'b0;
    intf.s_tready = 1'b1;
    test_reset();
    test_single_port();
    test_contention();
    test_fairness();
    test_backpressure();
    test_source_gap();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
